// File: rtl/phys_reg_map_table_multi_if.sv
// Rename/checkpoint bus between decode/dispatch (master) and the register map table (slave).
interface phys_reg_map_table_multi_if #(
    parameter int unsigned NUM_ARCH_REGS = 32,
    parameter int unsigned NUM_PHYS_REGS = 64,
    parameter int unsigned RENAME_WIDTH  = 2,
    parameter int unsigned CHECKPOINTS   = 4,
    parameter int unsigned ROB_INDEX_W   = 6
);
    localparam int unsigned AW = $clog2(NUM_ARCH_REGS);
    localparam int unsigned PW = $clog2(NUM_PHYS_REGS);
    localparam int unsigned CW = $clog2(CHECKPOINTS);
    localparam int unsigned SW = $clog2(RENAME_WIDTH) + 1;

    logic [RENAME_WIDTH-1:0][AW-1:0] src0_arch;
    logic [RENAME_WIDTH-1:0][AW-1:0] src1_arch;
    logic [RENAME_WIDTH-1:0][AW-1:0] old_dest_arch;
    logic [RENAME_WIDTH-1:0][PW-1:0] src0_phys;
    logic [RENAME_WIDTH-1:0][PW-1:0] src1_phys;
    logic [RENAME_WIDTH-1:0][PW-1:0] old_dest_phys;
    logic [RENAME_WIDTH-1:0]         rename_valid;
    logic [RENAME_WIDTH-1:0][AW-1:0] rename_dest_arch;
    logic [RENAME_WIDTH-1:0][PW-1:0] rename_dest_phys;
    logic                            revert_valid;
    logic [AW-1:0]                   revert_dest_arch;
    logic [PW-1:0]                   revert_safe_phys;
    logic                            save_valid;
    logic [SW-1:0]                   save_after_lane;
    logic [ROB_INDEX_W-1:0]          save_ROB_index;
    logic                            save_ready;
    logic [CW-1:0]                   save_safe_column;
    logic                            restore_valid;
    logic                            restore_failed;
    logic [CW-1:0]                   restore_column;
    logic [ROB_INDEX_W-1:0]          restore_ROB_index;
    logic                            restore_success;
    logic [CW:0]                     ckpt_count;

    modport master (
        output src0_arch, src1_arch, old_dest_arch,
        output rename_valid, rename_dest_arch, rename_dest_phys,
        output revert_valid, revert_dest_arch, revert_safe_phys,
        output save_valid, save_after_lane, save_ROB_index,
        output restore_valid, restore_failed, restore_column, restore_ROB_index,
        input  src0_phys, src1_phys, old_dest_phys,
        input  save_ready, save_safe_column, restore_success, ckpt_count
    );

    modport slave (
        input  src0_arch, src1_arch, old_dest_arch,
        input  rename_valid, rename_dest_arch, rename_dest_phys,
        input  revert_valid, revert_dest_arch, revert_safe_phys,
        input  save_valid, save_after_lane, save_ROB_index,
        input  restore_valid, restore_failed, restore_column, restore_ROB_index,
        output src0_phys, src1_phys, old_dest_phys,
        output save_ready, save_safe_column, restore_success, ckpt_count
    );
endinterface

// File: rtl/phys_reg_map_table_multi.sv
// Multi-lane physical register map table with a ring of checkpoint columns.
// Optional feature macro: PHYS_REG_MAP_TABLE_BYPASS_EN (intra-group read bypass).
module phys_reg_map_table_multi #(
    parameter int unsigned NUM_ARCH_REGS = 32,
    parameter int unsigned NUM_PHYS_REGS = 64,
    parameter int unsigned RENAME_WIDTH  = 2,
    parameter int unsigned CHECKPOINTS   = 4,
    parameter int unsigned ROB_INDEX_W   = 6
) (
    input logic                        CLK,
    input logic                        nRST,
    phys_reg_map_table_multi_if.slave  map_io
);
    localparam int unsigned PW = $clog2(NUM_PHYS_REGS);
    localparam int unsigned CW = $clog2(CHECKPOINTS);

    typedef logic [NUM_ARCH_REGS-1:0][PW-1:0] col_t;

    col_t [CHECKPOINTS-1:0]                  map_q, map_d;
    logic [CHECKPOINTS-1:0]                  valid_q, valid_d;
    logic [CHECKPOINTS-1:0][ROB_INDEX_W-1:0] rob_q, rob_d;
    logic [CW-1:0]                           w_q, w_d, safe_q, safe_d;
    logic [CW:0]                             count_q, count_d;

    logic [CW-1:0] w_next;
    logic          hit, fail_req, release_req, save_ok;

    logic [RENAME_WIDTH-1:0][PW-1:0] s0_phys, s1_phys, od_phys;

    assign w_next      = w_q + CW'(1);
    assign hit         = map_io.restore_valid && valid_q[map_io.restore_column] &&
                         (rob_q[map_io.restore_column] == map_io.restore_ROB_index);
    assign fail_req    = map_io.restore_valid && map_io.restore_failed;
    // Releasing the working column only reports success; it must stay valid.
    assign release_req = map_io.restore_valid && !map_io.restore_failed && hit &&
                         (map_io.restore_column != w_q);
    assign save_ok     = map_io.save_valid && !valid_q[w_next];

    assign map_io.save_ready       = !valid_q[w_next];
    assign map_io.restore_success  = hit;
    assign map_io.save_safe_column = safe_q;
    assign map_io.ckpt_count       = count_q;
    assign map_io.src0_phys        = s0_phys;
    assign map_io.src1_phys        = s1_phys;
    assign map_io.old_dest_phys    = od_phys;

    // Read the working column, optionally overridden by older lanes of the same group.
    always_comb begin
        s0_phys = '0;
        s1_phys = '0;
        od_phys = '0;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            s0_phys[k] = map_q[w_q][map_io.src0_arch[k]];
            s1_phys[k] = map_q[w_q][map_io.src1_arch[k]];
            od_phys[k] = map_q[w_q][map_io.old_dest_arch[k]];
`ifdef PHYS_REG_MAP_TABLE_BYPASS_EN
            // Ascending scan so the youngest matching producer wins.
            for (int j = 0; j < k; j++) begin
                if (map_io.rename_valid[j]) begin
                    if (map_io.rename_dest_arch[j] == map_io.src0_arch[k]) begin
                        s0_phys[k] = map_io.rename_dest_phys[j];
                    end
                    if (map_io.rename_dest_arch[j] == map_io.src1_arch[k]) begin
                        s1_phys[k] = map_io.rename_dest_phys[j];
                    end
                    if (map_io.rename_dest_arch[j] == map_io.old_dest_arch[k]) begin
                        od_phys[k] = map_io.rename_dest_phys[j];
                    end
                end
            end
`endif
        end
    end

    // Next state: restore-fail > revert > save/rename, release alongside.
    always_comb begin
        map_d   = map_q;
        valid_d = valid_q;
        rob_d   = rob_q;
        w_d     = w_q;
        // Cleared first so a save landing on the same column re-validates it.
        if (release_req) begin
            valid_d[map_io.restore_column] = 1'b0;
        end
        if (fail_req) begin
            if (hit) begin
                w_d                            = map_io.restore_column;
                valid_d                        = '0;
                valid_d[map_io.restore_column] = 1'b1;
            end
        end else if (map_io.revert_valid) begin
            map_d[w_q][map_io.revert_dest_arch] = map_io.revert_safe_phys;
            valid_d                             = '0;
            valid_d[w_q]                        = 1'b1;
        end else begin
            if (save_ok) begin
                map_d[w_next] = map_q[w_q];
            end
            for (int k = 0; k < RENAME_WIDTH; k++) begin
                if (map_io.rename_valid[k]) begin
                    if (!save_ok || k <= int'(map_io.save_after_lane)) begin
                        map_d[w_q][map_io.rename_dest_arch[k]] = map_io.rename_dest_phys[k];
                    end
                    if (save_ok) begin
                        map_d[w_next][map_io.rename_dest_arch[k]] = map_io.rename_dest_phys[k];
                    end
                end
            end
            if (save_ok) begin
                rob_d[w_q]      = map_io.save_ROB_index;
                rob_d[w_next]   = map_io.save_ROB_index;
                valid_d[w_next] = 1'b1;
                w_d             = w_next;
            end
        end
        count_d = '0;
        for (int c = 0; c < CHECKPOINTS; c++) begin
            count_d = count_d + (CW + 1)'(valid_d[c]);
        end
        safe_d = w_d;
    end

    // State registers; reset leaves column 0 as the identity mapping.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            map_q      <= '0;
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                map_q[0][i] <= PW'(i);
            end
            valid_q    <= '0;
            valid_q[0] <= 1'b1;
            rob_q      <= '0;
            w_q        <= '0;
            safe_q     <= '0;
            count_q    <= (CW + 1)'(1);
        end else begin
            map_q   <= map_d;
            valid_q <= valid_d;
            rob_q   <= rob_d;
            w_q     <= w_d;
            safe_q  <= safe_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_phys_reg_map_table_multi.sv
// Bench for phys_reg_map_table_multi: directed vector table plus randomized model comparison.
module tb_phys_reg_map_table_multi;
    localparam int NA = 32;
    localparam int NP = 64;
    localparam int RW = 2;
    localparam int CK = 4;
    localparam int RB = 6;
    localparam int AW = $clog2(NA);
    localparam int PW = $clog2(NP);
    localparam int CW = $clog2(CK);
    localparam int SW = $clog2(RW) + 1;

`ifdef PHYS_REG_MAP_TABLE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic CLK;
    logic nRST;

    phys_reg_map_table_multi_if #(
        .NUM_ARCH_REGS(NA), .NUM_PHYS_REGS(NP), .RENAME_WIDTH(RW),
        .CHECKPOINTS(CK), .ROB_INDEX_W(RB)
    ) bus ();

    phys_reg_map_table_multi #(
        .NUM_ARCH_REGS(NA), .NUM_PHYS_REGS(NP), .RENAME_WIDTH(RW),
        .CHECKPOINTS(CK), .ROB_INDEX_W(RB)
    ) dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .map_io(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;

    // Current stimulus, kept locally so the model never reads the bus back.
    int i_rv [RW];
    int i_rda[RW];
    int i_rdp[RW];
    int i_s0 [RW];
    int i_s1 [RW];
    int i_od [RW];
    int i_sv, i_sal, i_srob, i_rsv, i_rsf, i_rcol, i_rrob, i_rvv, i_rva, i_rvp;

    // Reference model state.
    int m_map  [CK][NA];
    bit m_valid[CK];
    int m_rob  [CK];
    int m_w;

    typedef struct {
        int rv;
        int rda0, rdp0, rda1, rdp1;
        int s0, s1;
        int sv, sal, srob;
        int rsv, rsf, rcol, rrob;
        int rvv, rva, rvp;
        int e0, e1, esucc, erdy, ecnt, esafe;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(string nm, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic idle();
        for (int k = 0; k < RW; k++) begin
            i_rv[k] = 0; i_rda[k] = 0; i_rdp[k] = 0; i_s0[k] = 0; i_s1[k] = 0; i_od[k] = 0;
        end
        i_sv = 0; i_sal = 0; i_srob = 0; i_rsv = 0; i_rsf = 0; i_rcol = 0; i_rrob = 0;
        i_rvv = 0; i_rva = 0; i_rvp = 0;
    endtask

    task automatic drive();
        for (int k = 0; k < RW; k++) begin
            bus.src0_arch[k]        = AW'(i_s0[k]);
            bus.src1_arch[k]        = AW'(i_s1[k]);
            bus.old_dest_arch[k]    = AW'(i_od[k]);
            bus.rename_valid[k]     = (i_rv[k] != 0);
            bus.rename_dest_arch[k] = AW'(i_rda[k]);
            bus.rename_dest_phys[k] = PW'(i_rdp[k]);
        end
        bus.save_valid        = (i_sv != 0);
        bus.save_after_lane   = SW'(i_sal);
        bus.save_ROB_index    = RB'(i_srob);
        bus.restore_valid     = (i_rsv != 0);
        bus.restore_failed    = (i_rsf != 0);
        bus.restore_column    = CW'(i_rcol);
        bus.restore_ROB_index = RB'(i_rrob);
        bus.revert_valid      = (i_rvv != 0);
        bus.revert_dest_arch  = AW'(i_rva);
        bus.revert_safe_phys  = PW'(i_rvp);
    endtask

    function automatic void model_reset();
        for (int c = 0; c < CK; c++) begin
            m_valid[c] = (c == 0);
            m_rob[c]   = 0;
            for (int r = 0; r < NA; r++) m_map[c][r] = (c == 0) ? r : 0;
        end
        m_w = 0;
    endfunction

    // Lane k sees column W, then the newest older-lane rename of the same register.
    function automatic int exp_read(int k, int tag);
        int v;
        v = m_map[m_w][tag];
        if (BYP) begin
            for (int j = 0; j < k; j++) if (i_rv[j] != 0 && i_rda[j] == tag) v = i_rdp[j];
        end
        return v;
    endfunction

    function automatic bit exp_hit();
        return i_rsv != 0 && m_valid[i_rcol] && m_rob[i_rcol] == i_rrob;
    endfunction

    function automatic int exp_count();
        int n;
        n = 0;
        for (int c = 0; c < CK; c++) n += int'(m_valid[c]);
        return n;
    endfunction

    function automatic void model_step();
        int  nw;
        bit  hit;
        bit  can_save;
        nw       = (m_w + 1) % CK;
        hit      = exp_hit();
        can_save = !m_valid[nw];
        if (i_rsv != 0 && i_rsf == 0 && hit && i_rcol != m_w) m_valid[i_rcol] = 1'b0;
        if (i_rsv != 0 && i_rsf != 0) begin
            if (hit) begin
                m_w = i_rcol;
                for (int c = 0; c < CK; c++) m_valid[c] = (c == i_rcol);
            end
        end else if (i_rvv != 0) begin
            m_map[m_w][i_rva] = i_rvp;
            for (int c = 0; c < CK; c++) m_valid[c] = (c == m_w);
        end else if (i_sv != 0 && can_save) begin
            for (int k = 0; k <= i_sal && k < RW; k++) if (i_rv[k] != 0) m_map[m_w][i_rda[k]] = i_rdp[k];
            m_map[nw] = m_map[m_w];
            for (int k = i_sal + 1; k < RW; k++) if (i_rv[k] != 0) m_map[nw][i_rda[k]] = i_rdp[k];
            m_rob[m_w]  = i_srob;
            m_rob[nw]   = i_srob;
            m_valid[nw] = 1'b1;
            m_w         = nw;
        end else begin
            for (int k = 0; k < RW; k++) if (i_rv[k] != 0) m_map[m_w][i_rda[k]] = i_rdp[k];
        end
    endfunction

    task automatic add(int rv, int rda0, int rdp0, int rda1, int rdp1, int s0, int s1,
                       int sv, int sal, int srob, int rsv, int rsf, int rcol, int rrob,
                       int rvv, int rva, int rvp,
                       int e0, int e1, int esucc, int erdy, int ecnt, int esafe);
        vec_t v;
        v.rv = rv; v.rda0 = rda0; v.rdp0 = rdp0; v.rda1 = rda1; v.rdp1 = rdp1;
        v.s0 = s0; v.s1 = s1; v.sv = sv; v.sal = sal; v.srob = srob;
        v.rsv = rsv; v.rsf = rsf; v.rcol = rcol; v.rrob = rrob;
        v.rvv = rvv; v.rva = rva; v.rvp = rvp;
        v.e0 = e0; v.e1 = e1; v.esucc = esucc; v.erdy = erdy; v.ecnt = ecnt; v.esafe = esafe;
        tbl.push_back(v);
    endtask

    initial begin
        // Directed sequence; expected outputs are the combinational values before the edge.
        //   rv rd0 rp0 rd1 rp1 s0 s1 sv sal srob rsv rsf col rrob rvv rva rvp  e0 e1 suc rdy cnt safe
        add(0, 0, 0, 0, 0,   5, 0,  0, 0, 0,   0, 0, 0, 0,   0, 0, 0,   5, 0, 0, 1, 1, 0);
        add(1, 3, 40, 0, 0,  3, 3,  0, 0, 0,   0, 0, 0, 0,   0, 0, 0,   3, BYP ? 40 : 3, 0, 1, 1, 0);
        add(3, 1, 33, 2, 34, 3, 1,  1, 0, 9,   0, 0, 0, 0,   0, 0, 0,   40, BYP ? 33 : 1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0,   2, 1,  0, 0, 0,   0, 0, 0, 0,   0, 0, 0,   34, 33, 0, 1, 2, 1);
        add(0, 0, 0, 0, 0,   2, 1,  0, 0, 0,   1, 1, 0, 9,   0, 0, 0,   34, 33, 1, 1, 2, 1);
        add(0, 0, 0, 0, 0,   2, 1,  0, 0, 0,   0, 0, 0, 0,   0, 0, 0,   2, 33, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0,   3, 0,  1, 0, 10,  0, 0, 0, 0,   0, 0, 0,   40, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0,   1, 2,  1, 0, 11,  0, 0, 0, 0,   0, 0, 0,   33, 2, 0, 1, 2, 1);
        add(0, 0, 0, 0, 0,   0, 0,  1, 0, 12,  0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 1, 3, 2);
        add(1, 6, 50, 0, 0,  6, 6,  1, 0, 13,  0, 0, 0, 0,   0, 0, 0,   6, BYP ? 50 : 6, 0, 0, 4, 3);
        add(0, 0, 0, 0, 0,   6, 0,  0, 0, 0,   1, 0, 0, 10,  0, 0, 0,   50, 0, 1, 0, 4, 3);
        add(0, 0, 0, 0, 0,   6, 0,  0, 0, 0,   1, 1, 1, 99,  0, 0, 0,   50, 0, 0, 1, 3, 3);
        add(1, 4, 44, 0, 0,  4, 4,  0, 0, 0,   0, 0, 0, 0,   0, 0, 0,   4, BYP ? 44 : 4, 0, 1, 3, 3);
        add(0, 0, 0, 0, 0,   4, 0,  0, 0, 0,   0, 0, 0, 0,   1, 4, 4,   44, 0, 0, 1, 3, 3);
        add(0, 0, 0, 0, 0,   4, 6,  0, 0, 0,   1, 0, 1, 11,  0, 0, 0,   4, 50, 0, 1, 1, 3);
        add(0, 0, 0, 0, 0,   0, 0,  0, 0, 0,   1, 0, 3, 12,  0, 0, 0,   0, 0, 1, 1, 1, 3);
        add(0, 0, 0, 0, 0,   0, 0,  1, 0, 20,  0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 1, 1, 3);
        add(0, 0, 0, 0, 0,   6, 4,  0, 0, 0,   0, 0, 0, 0,   0, 0, 0,   50, 4, 0, 1, 2, 0);

        // Reset state while nRST is held low.
        nRST = 1'b0;
        idle();
        i_s0[0] = 5;
        drive();
        #12;
        chk("reset src0_phys", int'(bus.src0_phys[0]), 5);
        chk("reset save_ready", int'(bus.save_ready), 1);
        chk("reset ckpt_count", int'(bus.ckpt_count), 1);
        chk("reset save_safe_column", int'(bus.save_safe_column), 0);
        chk("reset restore_success", int'(bus.restore_success), 0);
        @(posedge CLK); #1;
        nRST = 1'b1;

        foreach (tbl[n]) begin
            idle();
            i_rv[0] = tbl[n].rv & 1; i_rv[1] = (tbl[n].rv >> 1) & 1;
            i_rda[0] = tbl[n].rda0; i_rdp[0] = tbl[n].rdp0;
            i_rda[1] = tbl[n].rda1; i_rdp[1] = tbl[n].rdp1;
            i_s0[0] = tbl[n].s0; i_s0[1] = tbl[n].s1;
            i_sv = tbl[n].sv; i_sal = tbl[n].sal; i_srob = tbl[n].srob;
            i_rsv = tbl[n].rsv; i_rsf = tbl[n].rsf; i_rcol = tbl[n].rcol; i_rrob = tbl[n].rrob;
            i_rvv = tbl[n].rvv; i_rva = tbl[n].rva; i_rvp = tbl[n].rvp;
            drive();
            #4;
            chk($sformatf("vec%0d lane0 src0", n), int'(bus.src0_phys[0]), tbl[n].e0);
            chk($sformatf("vec%0d lane1 src0", n), int'(bus.src0_phys[1]), tbl[n].e1);
            chk($sformatf("vec%0d restore_success", n), int'(bus.restore_success), tbl[n].esucc);
            chk($sformatf("vec%0d save_ready", n), int'(bus.save_ready), tbl[n].erdy);
            chk($sformatf("vec%0d ckpt_count", n), int'(bus.ckpt_count), tbl[n].ecnt);
            chk($sformatf("vec%0d save_safe_column", n), int'(bus.save_safe_column), tbl[n].esafe);
            @(posedge CLK); #1;
        end

        // Asynchronous reset in mid-cycle: outputs must return at once, no edge needed.
        idle();
        i_s0[0] = 6;
        drive();
        #3;
        nRST = 1'b0;
        #1;
        chk("async reset src0_phys", int'(bus.src0_phys[0]), 6);
        chk("async reset save_safe_column", int'(bus.save_safe_column), 0);
        chk("async reset ckpt_count", int'(bus.ckpt_count), 1);
        chk("async reset save_ready", int'(bus.save_ready), 1);
        @(posedge CLK); #1;
        nRST = 1'b1;
        model_reset();

        // Randomized traffic against the reference model.
        for (int t = 0; t < 400; t++) begin
            for (int k = 0; k < RW; k++) begin
                i_rv[k]  = int'($urandom_range(0, 1));
                i_rda[k] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7))
                                                        : int'($urandom_range(0, NA - 1));
                i_rdp[k] = int'($urandom_range(0, NP - 1));
                i_s0[k]  = int'($urandom_range(0, 7));
                i_s1[k]  = int'($urandom_range(0, NA - 1));
                i_od[k]  = int'($urandom_range(0, 7));
            end
            i_sv   = ($urandom_range(0, 9) < 5) ? 1 : 0;
            i_sal  = int'($urandom_range(0, RW - 1));
            i_srob = int'($urandom_range(0, (1 << RB) - 1));
            i_rsv  = ($urandom_range(0, 9) < 2) ? 1 : 0;
            i_rsf  = ($urandom_range(0, 9) < 3) ? 1 : 0;
            i_rcol = int'($urandom_range(0, CK - 1));
            i_rrob = ($urandom_range(0, 3) != 0) ? m_rob[i_rcol]
                                                 : int'($urandom_range(0, (1 << RB) - 1));
            i_rvv  = ($urandom_range(0, 19) == 0) ? 1 : 0;
            i_rva  = int'($urandom_range(0, 7));
            i_rvp  = int'($urandom_range(0, NP - 1));
            drive();
            #4;
            for (int k = 0; k < RW; k++) begin
                chk($sformatf("rnd%0d lane%0d src0", t, k), int'(bus.src0_phys[k]), exp_read(k, i_s0[k]));
                chk($sformatf("rnd%0d lane%0d src1", t, k), int'(bus.src1_phys[k]), exp_read(k, i_s1[k]));
                chk($sformatf("rnd%0d lane%0d old_dest", t, k), int'(bus.old_dest_phys[k]), exp_read(k, i_od[k]));
            end
            chk($sformatf("rnd%0d restore_success", t), int'(bus.restore_success), int'(exp_hit()));
            chk($sformatf("rnd%0d save_ready", t), int'(bus.save_ready), int'(!m_valid[(m_w + 1) % CK]));
            chk($sformatf("rnd%0d ckpt_count", t), int'(bus.ckpt_count), exp_count());
            chk($sformatf("rnd%0d save_safe_column", t), int'(bus.save_safe_column), m_w);
            model_step();
            @(posedge CLK); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/phys_reg_map_table_multi.md
# phys_reg_map_table_multi

Parametrised, multi-lane successor of the physical register map table for the OoO core. It sits between decode and dispatch. Each cycle it renames up to RENAME_WIDTH instructions, with intra-group dependency bypass, and keeps a ring of CHECKPOINTS map-table columns for branch recovery. It adds full/empty back-pressure on checkpoint saves and lets a save and renames happen in the same cycle.

## Interface
- NUM_ARCH_REGS, 32, architectural registers; arch tag width AW = $clog2(NUM_ARCH_REGS)
- NUM_PHYS_REGS, 64, physical registers; phys tag width PW = $clog2(NUM_PHYS_REGS)
- RENAME_WIDTH, 2, rename lanes per cycle (1..4)
- CHECKPOINTS, 4, checkpoint columns, power of 2; column width CW = $clog2(CHECKPOINTS)
- ROB_INDEX_W, 6, ROB index width
- CLK, in, 1, clock. nRST, in, 1, reset: asynchronous, active-low
- src0_arch / src1_arch / old_dest_arch, in, [RENAME_WIDTH][AW], per-lane read tags
- src0_phys / src1_phys / old_dest_phys, out, [RENAME_WIDTH][PW], per-lane mappings
- rename_valid, in, [RENAME_WIDTH], per-lane rename enable
- rename_dest_arch, in, [RENAME_WIDTH][AW], per-lane rename destination
- rename_dest_phys, in, [RENAME_WIDTH][PW], per-lane new mapping
- revert_valid, in, 1, undo one rename
- revert_dest_arch, in, AW, register whose rename is undone
- revert_safe_phys, in, PW, mapping to write back
- save_valid, in, 1, request a checkpoint
- save_after_lane, in, $clog2(RENAME_WIDTH)+1, lane index the checkpoint follows
- save_ROB_index, in, ROB_INDEX_W, ROB index of the checkpointing branch
- save_ready, out, 1, a free column exists for a save
- save_safe_column, out, CW, column index that identifies the new checkpoint
- restore_valid, in, 1, branch resolution
- restore_failed, in, 1, 1 = mispredict (restore), 0 = correct (release)
- restore_column, in, CW, column named by the resolving branch
- restore_ROB_index, in, ROB_INDEX_W, tag to match against that column
- restore_success, out, 1, tag matched on a valid column (combinational)
- ckpt_count, out, CW+1, number of valid columns including the working column

## Operation
- State per column: valid, ROB_index, array[NUM_ARCH_REGS] of PW bits. Also a working pointer W.
- Reset state:
  - Column 0 is valid, ROB_index 0, array[i] = i.
  - All other columns are zeroed and invalid.
  - W = 0, ckpt_count = 1, save_ready = 1, save_safe_column = 0, restore_success = 0.
- Read path:
  - Lane k reads column W.
  - With bypass enabled, a source or old_dest tag of lane k that matches rename_dest_arch of a lower lane j < k (rename_valid[j] set) returns the youngest such rename_dest_phys. Among matching lanes, the highest j wins.
- Priority, one action per cycle: restore-fail > revert > save/rename. A release applies in parallel with any of these.
- Restore-fail (restore_valid & restore_failed):
  - On a match (column valid and ROB_index equal): W <- restore_column, all other columns are invalidated, restore_success = 1.
  - On a miss: no change, restore_success = 0.
  - Renames and saves in the same cycle are dropped.
- Revert: column W array[revert_dest_arch] <- revert_safe_phys. All columns except W are invalidated. Renames and saves in the same cycle are dropped.
- Rename only: each valid lane writes to column W in lane order. If two lanes target the same register, the higher lane wins.
- Save (save_valid & save_ready):
  - Lanes 0..save_after_lane rename into column W. Column W+1 (mod CHECKPOINTS) receives a copy of the result.
  - Lanes above save_after_lane rename into column W+1 only.
  - Both columns take ROB_index = save_ROB_index. Column W+1 becomes valid. W <- W+1.
- Save while full: save_ready = ~valid[W+1]. A save with save_ready = 0 is ignored. Renames in that cycle still apply to column W, and dispatch must stall.
- Release (restore_valid & ~restore_failed):
  - On a match and restore_column != W: the column is invalidated and restore_success = 1.
  - A match on W gives restore_success = 1 with no invalidation.
- ckpt_count is the popcount of the valid bits, registered.

## Timing
- Reads and restore_success are combinational from the current state (plus bypass). Writes become visible to reads the next cycle.
- save_safe_column = W, registered. Immediately after a save it names the new working column, which is the tag the ROB stores.
- A release and a save landing on the same column in one cycle: the save wins, and the column stays valid.
- W wraps from CHECKPOINTS-1 to 0.
- nRST asserted mid-cycle clears state immediately. Outputs return to their reset values asynchronously.

## Configuration
- PHYS_REG_MAP_TABLE_BYPASS_EN:
  - Defined: intra-group bypass is compiled in, as described above.
  - Undefined: all lanes read only the start-of-cycle column W, and the bypass comparators are removed. Dispatch must not group a consumer with its producer in the same cycle. Rename write ordering is unchanged.

## Test plan
- Reset, then read arch 5 on lane 0 -> src0_phys = 5, save_ready = 1, ckpt_count = 1.
- Lane 0 renames r3->p40 while lane 1 reads src0 = r3 in the same cycle -> lane 1 src0_phys = 40 with bypass, 3 without. The next cycle, lane 0 reads r3 -> 40.
- Save with save_after_lane = 0, ROB 9; lane 0 renames r1->p33, lane 1 renames r2->p34.
  - Column 0: r1 = 33, r2 = 2. Column 1: r1 = 33, r2 = 34. W = 1.
  - Restore-fail on column 0, ROB 9 -> success = 1, r2 reads 2, ckpt_count = 1.
- Perform CHECKPOINTS-1 saves without release -> save_ready = 0. A 4th save is ignored and W is unchanged.
  - Release the oldest (column 0 with its ROB tag) -> success = 1, save_ready = 1 the next cycle.
- Restore with a wrong ROB tag -> restore_success = 0 and state unchanged. Revert r4 to p4 after a rename -> r4 reads 4 and other columns become invalid.
